reg_file_wb: RTL and testbench
==============================

// Module: reg_file_wb
// PURPOSE
//  Architectural register file (x0..x31) for the RV32I pipeline; write side terminates the EX
//  stage's w_enable/w_addr/w_data write-back bus, read side feeds ID's r1/r2 operand fetch.
//  Provides same-cycle write->read bypass and a per-register busy scoreboard.
//  The scoreboard is set when ID issues a writing instruction and cleared on write-back, so ID can stall on RAW hazards.
// PARAMETERS
//  DATA_W     32   register width (RegBus)
//  ADDR_W     5    register index width (RegAddrBus)
//  NUM_REGS   32   number of architectural registers; must equal 2**ADDR_W
// PORTS
//  clk            in   1        rising-edge clock
//  rst_n          in   1        synchronous reset, active-low
//  w_enable_i     in   1        write-back enable from EX
//  w_addr_i       in   ADDR_W   write-back destination index
//  w_data_i       in   DATA_W   write-back data
//  r1_enable_i    in   1        read port 1 enable (ID)
//  r1_addr_i      in   ADDR_W   read port 1 index
//  r1_data_o      out  DATA_W   read port 1 data (combinational)
//  r1_busy_o      out  1        read port 1 source has an outstanding producer
//  r2_enable_i    in   1        read port 2 enable
//  r2_addr_i      in   ADDR_W   read port 2 index
//  r2_data_o      out  DATA_W   read port 2 data
//  r2_busy_o      out  1        read port 2 busy
//  issue_en_i     in   1        ID issues an instruction that will write issue_addr_i
//  issue_addr_i   in   ADDR_W   destination index of issued instruction
//  pending_cnt_o  out  ADDR_W+1 number of registers currently busy (registered)
// BEHAVIOUR
//  - Reset: at a clk edge with rst_n=0, all registers <= 0, all busy bits <= 0, pending_cnt_o <= 0.
//    While rst_n=0, r1/r2_data_o = 0 and r1/r2_busy_o = 0 regardless of inputs.
//  - Write: at a clk edge, if w_enable_i && w_addr_i!=0, regs[w_addr_i] <= w_data_i. Writes to x0 are dropped.
//  - Read (per port, combinational, zero latency), in priority order:
//    1) enable=0 -> data 0.  2) addr==0 -> data 0.
//    3) w_enable_i && w_addr_i==addr -> data w_data_i (bypass).  4) otherwise -> regs[addr].
//  - Both read ports may address the same register; both return identical data.
//  - Scoreboard busy[i], i=1..31; busy[0] is constant 0. At each clk edge:
//    * set   = issue_en_i && issue_addr_i==i
//    * clear = w_enable_i && w_addr_i==i
//    * set -> busy<=1 (set wins on simultaneous set+clear: new producer in flight);
//      else clear -> busy<=0; else hold.
//  - rN_busy_o = rN_enable_i && addr!=0 && busy[addr] && !(w_enable_i && w_addr_i==addr)
//    (a same-cycle write-back satisfies the read through bypass; a same-cycle issue does not affect it).
//  - pending_cnt_o: registered; tracks popcount(busy) after each edge.
//    Updated as +1 (new set), -1 (clear), or 0, computed per edge. Range 0..31, never wraps.
//  - Issue to an already-busy register keeps busy=1 and does not change the count (no nesting depth).
//  - Write-back to a non-busy register updates data only; count unchanged.
//  - Reset mid-operation discards all pending writes and busy state; the first edge with rst_n=1 behaves as from empty.
// TESTING
//  1) Reset: hold rst_n=0 2 cycles with w_enable_i=1,w_addr_i=5 -> x5 reads 0 after release; pending_cnt_o=0.
//  2) Write/read: write x3=0xDEADBEEF; next cycle r1_addr=3 -> 0xDEADBEEF.
//     Write x0=0xFFFFFFFF -> r2_addr=0 reads 0.
//  3) Bypass: same cycle w_enable_i=1,w_addr_i=7,w_data_i=0x1234 and r1_addr=r2_addr=7 -> both data 0x1234, busy 0.
//  4) Scoreboard: issue x9 -> next cycle r1_busy_o=1, pending_cnt_o=1.
//     Write-back x9 -> busy_o=0 that cycle via bypass; after edge busy=0, count=0.
//  5) Simultaneous set+clear on x4 (busy before) -> busy stays 1, count unchanged.
//     Issue x0 -> busy_o on x0 always 0, count unchanged.
//  6) Fill: issue x1..x31 on successive cycles -> pending_cnt_o=31.
//     Deassert rst_n for 1 cycle -> all busy 0, count 0.

Source files
------------

// File: rtl/reg_file_wb.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_wb
// Purpose  : RV32I architectural register file (x0..x31) with write-back
//            bypass to both read ports and a per-register busy scoreboard
//            used by ID to stall on RAW hazards.
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_wb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32   // must equal 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              w_enable_i,
  input  logic [ADDR_W-1:0] w_addr_i,
  input  logic [DATA_W-1:0] w_data_i,
  input  logic              r1_enable_i,
  input  logic [ADDR_W-1:0] r1_addr_i,
  output logic [DATA_W-1:0] r1_data_o,
  output logic              r1_busy_o,
  input  logic              r2_enable_i,
  input  logic [ADDR_W-1:0] r2_addr_i,
  output logic [DATA_W-1:0] r2_data_o,
  output logic              r2_busy_o,
  input  logic              issue_en_i,
  input  logic [ADDR_W-1:0] issue_addr_i,
  output logic [ADDR_W:0]   pending_cnt_o
);

  localparam logic [ADDR_W-1:0] c_zero_addr = '0;
  localparam logic [ADDR_W:0]   c_cnt_one   = {{ADDR_W{1'b0}}, 1'b1};

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;
  logic [ADDR_W:0]     r_pending_cnt;

  logic [NUM_REGS-1:0] w_busy_next;
  logic                w_wb_valid;
  logic                w_set_new;
  logic                w_clr_old;

  // A write-back to x0 is architecturally a no-op, so it never bypasses or clears
  assign w_wb_valid = w_enable_i && (w_addr_i != c_zero_addr);

  // Read-port mux: disable/x0 give zero, a same-cycle write-back wins over storage
  function automatic logic [DATA_W-1:0] f_read(
    input logic              en,
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored
  );
    if (!en || addr == c_zero_addr) return '0;
    if (w_enable_i && w_addr_i == addr) return w_data_i;
    return stored;
  endfunction

  // Combinational read data and busy flags, forced to zero while in reset
  always_comb begin
    r1_data_o = '0;
    r2_data_o = '0;
    r1_busy_o = 1'b0;
    r2_busy_o = 1'b0;
    if (rst_n) begin
      r1_data_o = f_read(r1_enable_i, r1_addr_i, r_regs[r1_addr_i]);
      r2_data_o = f_read(r2_enable_i, r2_addr_i, r_regs[r2_addr_i]);
      r1_busy_o = r1_enable_i && (r1_addr_i != c_zero_addr) && r_busy[r1_addr_i]
                  && !(w_enable_i && w_addr_i == r1_addr_i);
      r2_busy_o = r2_enable_i && (r2_addr_i != c_zero_addr) && r_busy[r2_addr_i]
                  && !(w_enable_i && w_addr_i == r2_addr_i);
    end
  end

  // Next busy vector: issue (set) beats write-back (clear); bit 0 stays zero
  always_comb begin
    w_busy_next = r_busy;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (issue_en_i && issue_addr_i == ADDR_W'(i))
        w_busy_next[i] = 1'b1;
      else if (w_enable_i && w_addr_i == ADDR_W'(i))
        w_busy_next[i] = 1'b0;
    end
  end

  // Count deltas: at most one register can become busy and one can become free per edge
  assign w_set_new = issue_en_i && (issue_addr_i != c_zero_addr) && !r_busy[issue_addr_i];
  assign w_clr_old = w_wb_valid && r_busy[w_addr_i]
                     && !(issue_en_i && issue_addr_i == w_addr_i);

  // Register storage: reset clears everything, x0 is never written
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_wb_valid) begin
      r_regs[w_addr_i] <= w_data_i;
    end
  end

  // Scoreboard and its running popcount
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy        <= '0;
      r_pending_cnt <= '0;
    end else begin
      r_busy <= w_busy_next;
      if (w_set_new && !w_clr_old)
        r_pending_cnt <= r_pending_cnt + c_cnt_one;
      else if (w_clr_old && !w_set_new)
        r_pending_cnt <= r_pending_cnt - c_cnt_one;
    end
  end

  assign pending_cnt_o = r_pending_cnt;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_wb.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_wb
// Purpose  : Self-checking bench for reg_file_wb (vector table + scoreboard)
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file_wb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        w_enable_i;
  logic [4:0]  w_addr_i;
  logic [31:0] w_data_i;
  logic        r1_enable_i;
  logic [4:0]  r1_addr_i;
  logic [31:0] r1_data_o;
  logic        r1_busy_o;
  logic        r2_enable_i;
  logic [4:0]  r2_addr_i;
  logic [31:0] r2_data_o;
  logic        r2_busy_o;
  logic        issue_en_i;
  logic [4:0]  issue_addr_i;
  logic [5:0]  pending_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  reg_file_wb #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .w_enable_i(w_enable_i), .w_addr_i(w_addr_i), .w_data_i(w_data_i),
    .r1_enable_i(r1_enable_i), .r1_addr_i(r1_addr_i),
    .r1_data_o(r1_data_o), .r1_busy_o(r1_busy_o),
    .r2_enable_i(r2_enable_i), .r2_addr_i(r2_addr_i),
    .r2_data_o(r2_data_o), .r2_busy_o(r2_busy_o),
    .issue_en_i(issue_en_i), .issue_addr_i(issue_addr_i),
    .pending_cnt_o(pending_cnt_o)
  );

  typedef struct {
    logic        we;  logic [4:0] wa;  logic [31:0] wd;
    logic        r1e; logic [4:0] r1a;
    logic        r2e; logic [4:0] r2a;
    logic        ie;  logic [4:0] ia;
    logic [31:0] e_r1d; logic e_r1b;
    logic [31:0] e_r2d; logic e_r2b;
    logic [5:0]  e_cnt;   // count expected after the edge
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  function automatic vec_t mk(
    input logic we, input logic [4:0] wa, input logic [31:0] wd,
    input logic r1e, input logic [4:0] r1a, input logic r2e, input logic [4:0] r2a,
    input logic ie, input logic [4:0] ia,
    input logic [31:0] e_r1d, input logic e_r1b,
    input logic [31:0] e_r2d, input logic e_r2b, input logic [5:0] e_cnt);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.r1e = r1e; v.r1a = r1a;
    v.r2e = r2e; v.r2a = r2a; v.ie = ie; v.ia = ia;
    v.e_r1d = e_r1d; v.e_r1b = e_r1b; v.e_r2d = e_r2d; v.e_r2b = e_r2b; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    w_enable_i = v.we;  w_addr_i = v.wa;  w_data_i = v.wd;
    r1_enable_i = v.r1e; r1_addr_i = v.r1a;
    r2_enable_i = v.r2e; r2_addr_i = v.r2a;
    issue_en_i = v.ie;  issue_addr_i = v.ia;
  endtask

  // Drive one vector at negedge, check combinational outputs, then the count after the edge
  task automatic apply(input vec_t v, input string tag);
    vec_t e;
    @(negedge clk);
    drive(v);
    exp_q.push_back(v);
    #1;
    e = exp_q.pop_front();
    check({tag, ".r1_data"}, r1_data_o, e.e_r1d);
    check({tag, ".r1_busy"}, {31'd0, r1_busy_o}, {31'd0, e.e_r1b});
    check({tag, ".r2_data"}, r2_data_o, e.e_r2d);
    check({tag, ".r2_busy"}, {31'd0, r2_busy_o}, {31'd0, e.e_r2b});
    @(posedge clk);
    #1;
    check({tag, ".cnt"}, {26'd0, pending_cnt_o}, {26'd0, e.e_cnt});
  endtask

  initial begin
    //             we wa  wd            r1e r1a  r2e r2a  ie ia   r1d           r1b r2d           r2b cnt
    vecs.push_back(mk(0, 0, 0,            1, 5,  1, 0,  0, 0,  0,            0,  0,            0,  0));
    vecs.push_back(mk(1, 3, 32'hDEADBEEF, 1, 3,  1, 5,  0, 0,  32'hDEADBEEF, 0,  0,            0,  0));
    vecs.push_back(mk(0, 0, 0,            1, 3,  0, 3,  0, 0,  32'hDEADBEEF, 0,  0,            0,  0));
    vecs.push_back(mk(1, 0, 32'hFFFFFFFF, 1, 0,  1, 0,  0, 0,  0,            0,  0,            0,  0));
    vecs.push_back(mk(1, 7, 32'h1234,     1, 7,  1, 7,  0, 0,  32'h1234,     0,  32'h1234,     0,  0));
    vecs.push_back(mk(0, 0, 0,            1, 9,  0, 0,  1, 9,  0,            0,  0,            0,  1));
    vecs.push_back(mk(0, 0, 0,            1, 9,  0, 9,  0, 0,  0,            1,  0,            0,  1));
    vecs.push_back(mk(1, 9, 32'h55,       1, 9,  1, 9,  0, 0,  32'h55,       0,  32'h55,       0,  0));
    vecs.push_back(mk(0, 0, 0,            1, 9,  0, 0,  0, 0,  32'h55,       0,  0,            0,  0));
    vecs.push_back(mk(0, 0, 0,            0, 0,  0, 0,  1, 4,  0,            0,  0,            0,  1));
    vecs.push_back(mk(1, 4, 32'h44,       1, 4,  1, 4,  1, 4,  32'h44,       0,  32'h44,       0,  1));
    vecs.push_back(mk(0, 0, 0,            1, 4,  0, 0,  0, 0,  32'h44,       1,  0,            0,  1));
    vecs.push_back(mk(0, 0, 0,            1, 0,  0, 0,  1, 0,  0,            0,  0,            0,  1));
    vecs.push_back(mk(0, 0, 0,            0, 4,  1, 4,  1, 4,  0,            0,  32'h44,       1,  1));
    vecs.push_back(mk(1, 4, 32'h99,       1, 4,  0, 0,  1, 10, 32'h99,       0,  0,            0,  1));
    vecs.push_back(mk(1, 12, 32'h12,      1, 10, 1, 12, 0, 0,  0,            1,  32'h12,       0,  1));
    vecs.push_back(mk(0, 0, 0,            1, 4,  1, 12, 0, 0,  32'h99,       0,  32'h12,       0,  1));

    // Reset held two cycles with a write and an issue pending on x5
    rst_n = 1'b0;
    drive(mk(1, 5, 32'hAAAA, 1, 5, 1, 5, 1, 5, 0, 0, 0, 0, 0));
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      check("rst.r1_data", r1_data_o, 32'h0);
      check("rst.r1_busy", {31'd0, r1_busy_o}, 32'h0);
      @(posedge clk);
      #1;
      check("rst.cnt", {26'd0, pending_cnt_o}, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // Fill the scoreboard (x10 already busy, so final count is 31)
    for (int a = 1; a < 32; a++)
      apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 5'(a), 0, 0, 0, 0, (a < 10) ? 6'(a + 1) : 6'(a)),
            $sformatf("fill%0d", a));
    apply(mk(0, 0, 0, 1, 31, 1, 1, 1, 5, 0, 1, 0, 1, 31), "sat");

    // One-cycle reset in the middle of a full scoreboard
    @(negedge clk);
    rst_n = 1'b0;
    drive(mk(0, 0, 0, 1, 3, 1, 31, 0, 0, 0, 0, 0, 0, 0));
    #1;
    check("mrst.r1_data", r1_data_o, 32'h0);
    check("mrst.r2_busy", {31'd0, r2_busy_o}, 32'h0);
    @(posedge clk);
    #1;
    check("mrst.cnt", {26'd0, pending_cnt_o}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(mk(0, 0, 0, 1, 3, 1, 31, 0, 0, 0, 0, 0, 0, 0), "post");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
